// File: rtl/uart_bus_bridge.sv
// Byte-stream command decoder: SET_ADDR / WRITE / IOWR packets drive a handshaked memory write port and IO strobes.
// Build macro CFG_BRIDGE_TIMEOUT_EN enables the mid-packet idle timeout (TIMEOUT_CYCLES).
module uart_bus_bridge #(
    parameter int unsigned        ADDR_W         = 20,
    parameter logic [ADDR_W-1:0]  RESET_ADDR     = ADDR_W'(20'hB0000),
    parameter int unsigned        TIMEOUT_CYCLES = 2500000
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [7:0]        iData,
    input  logic              iValid,
    output logic [ADDR_W-1:0] oAddr,
    output logic [7:0]        oData,
    output logic              oWr,
    input  logic              iReady,
    output logic [7:0]        oIoAddr,
    output logic [7:0]        oIoData,
    output logic              oIoWr,
    output logic              oBusy,
    output logic              oOverrun,
    output logic              oBadCmd
);

    localparam int unsigned       NB        = (ADDR_W + 7) / 8;
    localparam int unsigned       CNT_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_IO_ADDR,
        S_IO_DATA
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [8:0]        remaining;

    logic              take_cmd;
    logic              take_addr;
    logic              take_len;
    logic              take_data;
    logic              take_io_addr;
    logic              take_io_data;
    logic              bad_cmd;
    logic              slot_free;
    logic              timeout_hit;
    logic [ADDR_W-1:0] addr_mask;
    logic [ADDR_W-1:0] addr_ins;

    always_comb begin
        take_cmd     = iValid && (state == S_IDLE);
        take_addr    = iValid && (state == S_ADDR);
        take_len     = iValid && (state == S_LEN);
        take_data    = iValid && (state == S_DATA);
        take_io_addr = iValid && (state == S_IO_ADDR);
        take_io_data = iValid && (state == S_IO_DATA);
        bad_cmd      = take_cmd && (iData > 8'h03);
        slot_free    = !oWr || iReady;
    end

    // Little-endian address load: byte n lands in bits [8n+7:8n]; bits past ADDR_W fall off the shift.
    always_comb begin
        addr_mask = ADDR_W'(8'hFF) << {byte_cnt, 3'b000};
        addr_ins  = ADDR_W'(iData) << {byte_cnt, 3'b000};
    end

`ifdef CFG_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge iClk) begin
        if (iReset || iValid || (state == S_IDLE)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state != S_IDLE) && !iValid &&
                         (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_ref
    end
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (iValid) begin
            case (state)
                S_IDLE: begin
                    case (iData)
                        8'h01:   next_state = S_ADDR;
                        8'h02:   next_state = S_LEN;
                        8'h03:   next_state = S_IO_ADDR;
                        default: next_state = S_IDLE;
                    endcase
                end
                S_ADDR:    if (byte_cnt == LAST_BYTE) next_state = S_IDLE;
                S_LEN:     next_state = S_DATA;
                S_DATA:    if (remaining == 9'd1) next_state = S_IDLE;
                S_IO_ADDR: next_state = S_IO_DATA;
                S_IO_DATA: next_state = S_IDLE;
                default:   next_state = S_IDLE;
            endcase
        end else if (timeout_hit) begin
            next_state = S_IDLE;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            ptr       <= RESET_ADDR;
            byte_cnt  <= '0;
            remaining <= '0;
        end else begin
            if (take_cmd && (iData == 8'h01)) begin
                byte_cnt <= '0;
            end
            if (take_addr) begin
                ptr      <= (ptr & ~addr_mask) | addr_ins;
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (take_len) begin
                remaining <= (iData == 8'h00) ? 9'd256 : {1'b0, iData};
            end
            // Dropped (overrun) bytes still advance ptr/remaining so framing stays aligned.
            if (take_data) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - 9'd1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            oAddr    <= '0;
            oData    <= '0;
            oWr      <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            if (take_data && slot_free) begin
                oAddr <= ptr;
                oData <= iData;
                oWr   <= 1'b1;
            end else if (oWr && iReady) begin
                oWr <= 1'b0;
            end
            if (take_data && !slot_free) begin
                oOverrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            oIoAddr <= '0;
            oIoData <= '0;
            oIoWr   <= 1'b0;
            oBadCmd <= 1'b0;
        end else begin
            if (take_io_addr) begin
                oIoAddr <= iData;
            end
            if (take_io_data) begin
                oIoData <= iData;
            end
            oIoWr   <= take_io_data;
            oBadCmd <= bad_cmd || timeout_hit;
        end
    end

    assign oBusy = (state != S_IDLE) || oWr;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: packet-level reference model with a write scoreboard.
// Build with +define+CFG_BRIDGE_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=100).
module tb_uart_bus_bridge;

    localparam int unsigned      AW    = 20;
    localparam logic [AW-1:0]    RST_A = 20'hB0000;

    logic          iClk = 1'b0;
    logic          iReset;
    logic [7:0]    iData;
    logic          iValid;
    logic          iReady;
    logic [AW-1:0] oAddr;
    logic [7:0]    oData;
    logic          oWr;
    logic [7:0]    oIoAddr;
    logic [7:0]    oIoData;
    logic          oIoWr;
    logic          oBusy;
    logic          oOverrun;
    logic          oBadCmd;

    always #5 iClk = ~iClk;

    uart_bus_bridge #(
        .ADDR_W(AW),
        .RESET_ADDR(RST_A),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .iClk(iClk),
        .iReset(iReset),
        .iData(iData),
        .iValid(iValid),
        .oAddr(oAddr),
        .oData(oData),
        .oWr(oWr),
        .iReady(iReady),
        .oIoAddr(oIoAddr),
        .oIoData(oIoData),
        .oIoWr(oIoWr),
        .oBusy(oBusy),
        .oOverrun(oOverrun),
        .oBadCmd(oBadCmd)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t           exp_q[$];
    logic [AW-1:0] mptr;
    bit            mpend;
    bit            movr;
    int unsigned   tests = 0;
    int unsigned   fails = 0;
    int unsigned   bad_seen = 0;
    int unsigned   io_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted memory write must match the oldest expected write.
    always @(negedge iClk) begin
        wr_t e;
        if (!iReset) begin
            if (oBadCmd) bad_seen++;
            if (oIoWr) io_seen++;
            if (oWr && iReady) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL wr_unexpected observed=%0h/%0h expected=none", oAddr, oData);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    tests++;
                    assert ({oAddr, oData} === {e.a, e.d}) else begin
                        fails++;
                        $error("FAIL wr_accept observed=%0h/%0h expected=%0h/%0h", oAddr, oData, e.a, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bit rnd(input int unsigned pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    // One clock of stimulus; the model decides whether a data byte is taken or dropped.
    task automatic cycle(input bit v, input logic [7:0] b, input bit r, input bit is_data);
        iValid = v;
        iData  = b;
        iReady = r;
        if (v && is_data) begin
            if (!mpend || r) begin
                exp_q.push_back('{a: mptr, d: b});
                mpend = 1'b1;
            end else begin
                movr = 1'b1;
            end
            mptr = mptr + 1'b1;
        end else if (mpend && r) begin
            mpend = 1'b0;
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic idle(input int unsigned n, input int unsigned pct);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, rnd(pct), 1'b0);
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        iReset = 1'b0;
        exp_q.delete();
        mpend = 1'b0;
        movr  = 1'b0;
        mptr  = RST_A;
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 64 && exp_q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_owr", 32'(oWr), 32'd0);
    endtask

    task automatic send_set_addr(input logic [AW-1:0] a, input int unsigned pct);
        logic [23:0] a24;
        a24 = {4'h0, a};
        cycle(1'b1, 8'h01, rnd(pct), 1'b0);
        for (int unsigned i = 0; i < 3; i++) cycle(1'b1, a24[8*i +: 8], rnd(pct), 1'b0);
        mptr = a;
    endtask

    task automatic send_write(input logic [7:0] bytes[$], input int unsigned pct, input int unsigned gap);
        int unsigned n;
        n = bytes.size();
        cycle(1'b1, 8'h02, rnd(pct), 1'b0);
        cycle(1'b1, n[7:0], rnd(pct), 1'b0);
        foreach (bytes[i]) begin
            cycle(1'b1, bytes[i], rnd(pct), 1'b1);
            idle($urandom_range(gap, 0), pct);
        end
    endtask

    task automatic send_iowr(input logic [7:0] a, input logic [7:0] d, input int unsigned pct);
        int unsigned io0;
        io0 = io_seen;
        cycle(1'b1, 8'h03, rnd(pct), 1'b0);
        cycle(1'b1, a, rnd(pct), 1'b0);
        cycle(1'b1, d, rnd(pct), 1'b0);
        chk("io_strobe", 32'(oIoWr), 32'd1);
        chk("io_addr", 32'(oIoAddr), 32'(a));
        chk("io_data", 32'(oIoData), 32'(d));
        cycle(1'b0, 8'h00, rnd(pct), 1'b0);
        chk("io_strobe_len", io_seen - io0, 32'd1);
        chk("io_strobe_low", 32'(oIoWr), 32'd0);
    endtask

    task automatic send_bad(input logic [7:0] c, input int unsigned pct);
        int unsigned b0;
        b0 = bad_seen;
        cycle(1'b1, c, rnd(pct), 1'b0);
        chk("badcmd_pulse", 32'(oBadCmd), 32'd1);
        cycle(1'b1, 8'h00, rnd(pct), 1'b0);
        chk("badcmd_low", 32'(oBadCmd), 32'd0);
        cycle(1'b0, 8'h00, rnd(pct), 1'b0);
        chk("badcmd_count", bad_seen - b0, 32'd1);
    endtask

    initial begin
        logic [7:0]  q[$];
        int unsigned b0;

        iReset = 1'b1;
        iValid = 1'b0;
        iData  = 8'h00;
        iReady = 1'b0;
        exp_q.delete();
        mpend = 1'b0;
        movr  = 1'b0;
        mptr  = RST_A;
        @(posedge iClk);
        #1;
        @(posedge iClk);
        #1;
        chk("rst_owr", 32'(oWr), 32'd0);
        chk("rst_iowr", 32'(oIoWr), 32'd0);
        chk("rst_overrun", 32'(oOverrun), 32'd0);
        chk("rst_badcmd", 32'(oBadCmd), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_addr", 32'(oAddr), 32'd0);
        chk("rst_data", 32'(oData), 32'd0);
        chk("rst_ioaddr", 32'(oIoAddr), 32'd0);
        chk("rst_iodata", 32'(oIoData), 32'd0);
        iReset = 1'b0;

        q = '{8'hAA, 8'hBB, 8'hCC};
        send_write(q, 100, 0);
        drain();
        chk("burst3_busy", 32'(oBusy), 32'd0);
        chk("burst3_overrun", 32'(oOverrun), 32'd0);

        send_set_addr(20'hF1234, 100);
        q = '{8'h55};
        send_write(q, 100, 0);
        q = '{8'h66};
        send_write(q, 100, 0);
        drain();

        do_reset();
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        chk("latency_owr", 32'(oWr), 32'd1);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        chk("stall_owr", 32'(oWr), 32'd1);
        chk("stall_addr", 32'(oAddr), 32'(RST_A));
        chk("stall_data", 32'(oData), 32'h11);
        chk("stall_overrun", 32'(oOverrun), 32'(movr));
        drain();
        q = '{8'h33};
        send_write(q, 100, 0);
        drain();

        send_iowr(8'h42, 8'h99, 100);
        send_bad(8'h7E, 100);
        chk("bad_busy", 32'(oBusy), 32'd0);

        send_set_addr(20'hFFFFF, 100);
        cycle(1'b1, 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 8'h01, 1'b1, 1'b1);
        cycle(1'b1, 8'h02, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_owr", 32'(oWr), 32'd1);
        chk("wrap_addr", 32'(oAddr), 32'd0);
        chk("wrap_data", 32'(oData), 32'h02);
        do_reset();
        chk("midrst_owr", 32'(oWr), 32'd0);
        chk("midrst_busy", 32'(oBusy), 32'd0);
        q = '{8'h77};
        send_write(q, 100, 0);
        drain();

        send_set_addr(AW'($urandom), 100);
        q.delete();
        for (int unsigned i = 0; i < 256; i++) q.push_back(8'($urandom));
        send_write(q, 100, 0);
        drain();
        chk("len256_busy", 32'(oBusy), 32'd0);

        for (int unsigned k = 0; k < 30; k++) begin
            case ($urandom_range(3, 0))
                0: send_set_addr(AW'($urandom), 70);
                1: begin
                    q.delete();
                    for (int unsigned i = 0; i < $urandom_range(6, 1); i++) q.push_back(8'($urandom));
                    send_write(q, 60, 2);
                end
                2: send_iowr(8'($urandom), 8'($urandom), 70);
                default: send_bad(8'($urandom_range(255, 4)), 70);
            endcase
        end
        drain();
        chk("random_overrun", 32'(oOverrun), 32'(movr));

        cycle(1'b1, 8'h02, 1'b1, 1'b0);
        cycle(1'b1, 8'h05, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b1);
        b0 = bad_seen;
        idle(103, 100);
`ifdef CFG_BRIDGE_TIMEOUT_EN
        chk("timeout_pulse", bad_seen - b0, 32'd1);
        chk("timeout_busy", 32'(oBusy), 32'd0);
        send_iowr(8'h5A, 8'hC3, 100);
`else
        chk("stall_nopulse", bad_seen - b0, 32'd0);
        chk("stall_busy", 32'(oBusy), 32'd1);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 8'(8'h22 + i), 1'b1, 1'b1);
`endif
        drain();
        chk("final_busy", 32'(oBusy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
Byte-stream command decoder that sits between uartRx and the memory/IO fabric. It is the parametrised successor to the "every rx byte writes to an incrementing address" scheme.
- Host sends framed packets: set address, burst write with explicit length, single IO-port write.
- Memory writes use a ready handshake. IO writes are fire-and-forget strobes.
- Replaces the ad-hoc wr_addr counter and the adlib shift-register decode at top level.

Parameters:
ADDR_W, 20, width of memory address pointer and oAddr
RESET_ADDR, 20'hB0000, pointer value after reset (truncated to ADDR_W)
TIMEOUT_CYCLES, 2500000, idle cycles mid-packet before abort (100 ms at 25 MHz); used only with the optional feature

Ports:
iClk  in  1  system clock
iReset  in  1  synchronous reset, active-high
iData  in  8  received byte
iValid  in  1  single-cycle strobe; iData valid this cycle
oAddr  out  ADDR_W  memory write address, held while oWr=1
oData  out  8  memory write data, held while oWr=1
oWr  out  1  memory write request; held until accepted (oWr && iReady)
iReady  in  1  fabric accepts the write this cycle
oIoAddr  out  8  IO port index
oIoData  out  8  IO port data
oIoWr  out  1  single-cycle IO write strobe
oBusy  out  1  (state != IDLE) || oWr
oOverrun  out  1  sticky; a data byte was dropped because a write was still pending
oBadCmd  out  1  single-cycle pulse on an unrecognised command byte

Behaviour:
- Clock and reset: one clock, iClk. Reset is synchronous and active-high on iReset.
- Reset values: state=IDLE, ptr=RESET_ADDR, oWr=0, oIoWr=0, oOverrun=0, oBadCmd=0. oAddr, oData, oIoAddr and oIoData reset to 0.
- Bytes are consumed only on iValid. Nothing changes state without iValid, except the handshake and the timeout.
- NB = ceil(ADDR_W/8) address bytes.
- Commands in IDLE:
  - 0x00 NOP: ignored, stays IDLE; used by the host to resync.
  - 0x01 SET_ADDR: go to ADDR, byte counter = 0.
  - 0x02 WRITE: go to LEN.
  - 0x03 IOWR: go to IO_ADDR.
  - Any other value: pulse oBadCmd next cycle, stay IDLE.
- ADDR state:
  - NB bytes, little-endian, shifted into ptr.
  - Bits above ADDR_W are discarded.
  - After the NB-th byte, go to IDLE. The new ptr applies from the next accepted data byte.
- LEN state:
  - Byte sets remaining = byte. Value 0 means 256 (9-bit counter). Go to DATA.
- DATA state:
  - On each byte: oAddr <= ptr, oData <= byte, oWr <= 1 on the next cycle. Also ptr <= ptr+1 (wraps modulo 2^ADDR_W) and remaining <= remaining-1.
  - When remaining reaches 0 on this byte, go to IDLE.
- Handshake:
  - oWr stays high with oAddr/oData stable until the cycle where iReady=1. oWr drops the cycle after that.
  - Latency from iValid to first oWr is 1 cycle.
  - If iReady=1 on the same cycle a new data byte arrives, the new byte is accepted: the slot frees and reloads, and oWr stays high.
- Overrun:
  - A data byte arriving while oWr=1 and iReady=0 is dropped and sets oOverrun.
  - ptr and remaining still advance so framing and addressing stay consistent.
  - oOverrun clears only on reset.
- IO_ADDR state: byte -> oIoAddr, go to IO_DATA.
- IO_DATA state: byte -> oIoData, oIoWr=1 for exactly 1 cycle, go to IDLE.
- A pending oWr is independent of the parser. The parser may return to IDLE and take new commands, including SET_ADDR, while oWr waits. A pending write keeps its latched oAddr.
- Reset mid-packet or mid-handshake: everything returns to reset values immediately. Any pending write is abandoned.

Optional Feature:
Macro CFG_BRIDGE_TIMEOUT_EN.
- When defined:
  - An idle counter clears on every iValid and counts while state != IDLE.
  - At TIMEOUT_CYCLES the parser forces state=IDLE and pulses oBadCmd for 1 cycle.
  - A pending oWr is unaffected.
- When not defined: no counter is present, and the parser waits indefinitely mid-packet.

Test Plan:
- Reset, then 02 03 AA BB CC with iReady=1 -> three oWr at B0000/AA, B0001/BB, B0002/CC; oBusy=0 afterwards; oOverrun=0.
- 01 34 12 0F then 02 01 55 (ADDR_W=20, NB=3) -> oWr at 0xF1234 with data 0x55; ptr=0xF1235.
- iReady=0 held, send 02 02 11 22 -> oWr holds 0x11 at B0000, byte 0x22 dropped, oOverrun=1. Raise iReady -> single accept; next write goes to B0002.
- 03 42 99 -> oIoAddr=0x42, oIoData=0x99, oIoWr high exactly 1 cycle. 0x7E in IDLE -> oBadCmd pulse, state IDLE; following 00 is ignored silently.
- SET_ADDR to 0xFFFFF, then 02 02 01 02 -> writes at FFFFF then 00000 (wrap). Assert iReset during the second oWr -> oWr=0 the next cycle, ptr=B0000.
- With CFG_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 02 05 11 then stall 100 cycles -> oBadCmd pulse, state IDLE. Next byte 03 is parsed as IOWR. Without the macro, the same stall leaves the parser in DATA.
